// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of one byte-addressed,
// big-endian, 32-bit-word data memory. Every transaction takes exactly
// three cycles: the request is sampled in IDLE, the memory is accessed in
// ACCESS, and the ack pulse is given in DONE.
//
// Configuration macro: MEM_ARB_ALIGN_CHECK_EN
//   defined   - word-misaligned requests (addr[1:0] != 0) never reach the
//               memory and complete with err<owner> = 1.
//   undefined - every address is forwarded unchanged and err0/err1 stay 0.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   req/we/addr/wd (0, 1)  requester inputs, held stable until the ack
//   ack0, ack1             one-cycle completion pulses
//   rd0, rd1               registered read data, held until the next read ack
//   err0, err1             misalignment flags, valid together with the ack
//   busy                   high whenever the FSM is not in IDLE
//   mem_address/mem_wd/mem_we/mem_rd  data-memory port (mem_rd is combinational)
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  output logic          err0,
  output logic          err1,
  output logic          busy,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_r;
  logic          owner_r;
  logic          last_served_r;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wd_r;
  logic          ack0_r;
  logic          ack1_r;
  logic          err0_r;
  logic          err1_r;
  logic          busy_r;
  logic [DW-1:0] rd0_r;
  logic [DW-1:0] rd1_r;
  logic          winner_s;
  logic          misaligned_s;

  // Misalignment is judged on the latched address, so it cannot change
  // mid-transaction even if the requester misbehaves.
`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign misaligned_s = (addr_r[1:0] != 2'b00);
`else
  assign misaligned_s = 1'b0;
`endif

  // Round-robin pick: on a tie the port that was not served last wins.
  always_comb begin
    winner_s = 1'b0;
    if (req0 && req1) begin
      winner_s = ~last_served_r;
    end else if (req1) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // The address and write data are the latched copies, so they naturally
  // hold their last value outside ACCESS. The write enable is also gated
  // by rst directly so a reset landing in ACCESS never commits a write.
  assign mem_address = addr_r;
  assign mem_wd      = wd_r;
  assign mem_we      = (state_r == ACCESS) & we_r & ~misaligned_s & ~rst;

  assign ack0 = ack0_r;
  assign ack1 = ack1_r;
  assign err0 = err0_r;
  assign err1 = err1_r;
  assign rd0  = rd0_r;
  assign rd1  = rd1_r;
  assign busy = busy_r;

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      last_served_r <= 1'b1;
      owner_r       <= 1'b0;
      we_r          <= 1'b0;
      addr_r        <= {AW{1'b0}};
      wd_r          <= {DW{1'b0}};
      ack0_r        <= 1'b0;
      ack1_r        <= 1'b0;
      err0_r        <= 1'b0;
      err1_r        <= 1'b0;
      rd0_r         <= {DW{1'b0}};
      rd1_r         <= {DW{1'b0}};
      busy_r        <= 1'b0;
    end else begin
      // ack/err are pulses; only the ACCESS->DONE edge raises them.
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
      err0_r <= 1'b0;
      err1_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req0 || req1) begin
            owner_r <= winner_s;
            we_r    <= winner_s ? we1   : we0;
            addr_r  <= winner_s ? addr1 : addr0;
            wd_r    <= winner_s ? wd1   : wd0;
            state_r <= ACCESS;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        ACCESS: begin
          state_r <= DONE;
          busy_r  <= 1'b1;
          if (owner_r) begin
            ack1_r <= 1'b1;
            err1_r <= misaligned_s;
          end else begin
            ack0_r <= 1'b1;
            err0_r <= misaligned_s;
          end
          // Reads capture the combinational memory word at the end of ACCESS.
          if (!we_r && !misaligned_s) begin
            if (owner_r) begin
              rd1_r <= mem_rd;
            end else begin
              rd0_r <= mem_rd;
            end
          end
        end
        DONE: begin
          state_r       <= IDLE;
          busy_r        <= 1'b0;
          last_served_r <= owner_r;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, hand-written
// multi-cycle sequences, and random traffic against a transaction-level model.
module tb_mem_arbiter;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clr;
  logic        t_req  [2];
  logic        t_we   [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wd   [2];
  logic        ack0, ack1, err0, err1, busy, mem_we;
  logic [31:0] rd0, rd1, mem_address, mem_wd, mem_rd;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req0(t_req[0]), .req1(t_req[1]), .we0(t_we[0]), .we1(t_we[1]),
    .addr0(t_addr[0]), .addr1(t_addr[1]), .wd0(t_wd[0]), .wd1(t_wd[1]),
    .ack0(ack0), .ack1(ack1), .rd0(rd0), .rd1(rd1), .err0(err0), .err1(err1),
    .busy(busy), .mem_address(mem_address), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_rd(mem_rd)
  );

  // 256-byte big-endian data memory, wrapping on the low address byte.
  logic [7:0] mem [256];
  logic [7:0] ma0, ma1, ma2, ma3;
  assign ma0 = mem_address[7:0];
  assign ma1 = ma0 + 8'd1;
  assign ma2 = ma0 + 8'd2;
  assign ma3 = ma0 + 8'd3;
  assign mem_rd = {mem[ma0], mem[ma1], mem[ma2], mem[ma3]};

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[ma0] <= mem_wd[31:24];
      mem[ma1] <= mem_wd[23:16];
      mem[ma2] <= mem_wd[15:8];
      mem[ma3] <= mem_wd[7:0];
    end
  end

  // Reference model state: memory image, per-port read registers, last served.
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_rd  [2];
  int          m_last;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    ref_word[31:24] = ref_mem[b];
    b = b + 8'd1;
    ref_word[23:16] = ref_mem[b];
    b = b + 8'd1;
    ref_word[15:8] = ref_mem[b];
    b = b + 8'd1;
    ref_word[7:0] = ref_mem[b];
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = a[7:0] + 8'(i);
      ref_mem[b] = d[31 - 8*i -: 8];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 1) ? ack1 : ack0;
  endfunction

  function automatic logic err_of(input int p);
    return (p == 1) ? err1 : err0;
  endfunction

  task automatic new_req(input int p);
    logic [31:0] a;
    a = $urandom();
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    t_req[p]  = 1'b1;
    t_we[p]   = 1'($urandom_range(0, 1));
    t_addr[p] = a;
    t_wd[p]   = $urandom();
  endtask

  // One 3-cycle transaction; entered and left at an IDLE-cycle negedge with
  // at least one request already driven.
  task automatic slot(output logic got_err);
    int   w;
    logic mis;
    if (t_req[0] && t_req[1]) w = (m_last == 1) ? 0 : 1;
    else w = t_req[1] ? 1 : 0;
    mis = ALIGN_CHK && (t_addr[w][1:0] != 2'b00);
    @(negedge clk);  // ACCESS
    chk1("access_busy", busy, 1'b1);
    chk1("access_mem_we", mem_we, t_we[w] && !mis);
    chk("access_mem_address", mem_address, t_addr[w]);
    if (t_we[w]) chk("access_mem_wd", mem_wd, t_wd[w]);
    // A late request on the other port must wait, not be lost.
    if (!t_req[1-w] && $urandom_range(0, 2) == 0) new_req(1 - w);
    @(negedge clk);  // DONE
    if (!mis) begin
      if (t_we[w]) ref_write(t_addr[w], t_wd[w]);
      else exp_rd[w] = ref_word(t_addr[w]);
    end
    got_err = err_of(w);
    chk1("done_ack_owner", ack_of(w), 1'b1);
    chk1("done_ack_other", ack_of(1 - w), 1'b0);
    chk1("done_err_owner", err_of(w), mis);
    chk1("done_err_other", err_of(1 - w), 1'b0);
    chk("done_rd0", rd0, exp_rd[0]);
    chk("done_rd1", rd1, exp_rd[1]);
    chk1("done_mem_we", mem_we, 1'b0);
    m_last   = w;
    t_req[w] = 1'b0;
    @(negedge clk);  // IDLE
    chk1("idle_ack0", ack0, 1'b0);
    chk1("idle_ack1", ack1, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_mem_we", mem_we, 1'b0);
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic e;
    rst = 1'b1;
    mem_clr = 1'b1;
    for (int p = 0; p < 2; p++) begin
      t_req[p] = 1'b0; t_we[p] = 1'b0; t_addr[p] = 32'd0; t_wd[p] = 32'd0;
      exp_rd[p] = 32'd0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    m_last = 1;

    vt[0] = '{0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
    vt[1] = '{1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0};
    vt[2] = '{0, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0};
    vt[3] = '{1, 1'b1, 32'h30, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0};
    vt[4] = '{0, 1'b0, 32'h30, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0};
    vt[5] = '{0, 1'b1, 32'h22, 32'hA5A5A5A5, 1'b0, 32'h0, ALIGN_CHK};
    vt[6] = '{1, 1'b0, 32'h20, 32'h0, 1'b1, (ALIGN_CHK ? 32'h00000000 : 32'h0000A5A5), 1'b0};
    vt[7] = '{1, 1'b0, 32'h24, 32'h0, 1'b1, (ALIGN_CHK ? 32'h00000000 : 32'hA5A50000), 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk1("rst_ack0", ack0, 1'b0);
    chk1("rst_ack1", ack1, 1'b0);
    chk1("rst_err0", err0, 1'b0);
    chk1("rst_err1", err1, 1'b0);
    chk("rst_rd0", rd0, 32'd0);
    chk("rst_rd1", rd1, 32'd0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);

    // Both ports held high from reset release: acks 0,1,0,1 every 3 cycles.
    mem_clr = 1'b0;
    rst = 1'b0;
    t_req[0] = 1'b1; t_addr[0] = 32'h40;
    t_req[1] = 1'b1; t_addr[1] = 32'h44;
    for (int k = 1; k <= 11; k++) begin
      logic x0, x1;
      @(negedge clk);
      x0 = (k % 3 == 2) && ((k / 3) % 2 == 0);
      x1 = (k % 3 == 2) && ((k / 3) % 2 == 1);
      chk1($sformatf("rr_ack0_c%0d", k), ack0, x0);
      chk1($sformatf("rr_ack1_c%0d", k), ack1, x1);
    end
    t_req[0] = 1'b0;
    t_req[1] = 1'b0;
    @(negedge clk);
    chk1("rr_busy_after", busy, 1'b0);
    m_last = 1;

    // Reset landing in the ACCESS cycle of a port 1 write.
    t_req[1] = 1'b1; t_we[1] = 1'b1; t_addr[1] = 32'h20; t_wd[1] = 32'h12345678;
    @(negedge clk);
    chk1("abort_busy", busy, 1'b1);
    chk1("abort_we_before", mem_we, 1'b1);
    rst = 1'b1;
    #1;
    chk1("abort_we_gated", mem_we, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    t_req[1] = 1'b0;
    chk1("abort_ack1_a", ack1, 1'b0);
    chk1("abort_busy_a", busy, 1'b0);
    @(negedge clk);
    chk1("abort_ack1_b", ack1, 1'b0);
    chk1("abort_ack0_b", ack0, 1'b0);
    chk1("abort_busy_b", busy, 1'b0);
    for (int i = 0; i < 4; i++) chk($sformatf("abort_mem_%0d", i), {24'd0, mem[8'h20 + i]}, 32'd0);
    m_last = 1;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      t_req[vt[i].port]  = 1'b1;
      t_we[vt[i].port]   = vt[i].we;
      t_addr[vt[i].port] = vt[i].addr;
      t_wd[vt[i].port]   = vt[i].wd;
      slot(e);
      chk1($sformatf("vec%0d_err", i), e, vt[i].exp_err);
      if (vt[i].chk_rd) chk($sformatf("vec%0d_rd", i), (vt[i].port == 1) ? rd1 : rd0, vt[i].exp_rd);
      if (i == 0) begin
        chk("w34_byte10", {24'd0, mem[8'h10]}, 32'hDE);
        chk("w34_byte11", {24'd0, mem[8'h11]}, 32'hAD);
        chk("w34_byte12", {24'd0, mem[8'h12]}, 32'hBE);
        chk("w34_byte13", {24'd0, mem[8'h13]}, 32'hEF);
      end
    end

    // Random traffic with contention and late requests.
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!t_req[p] && $urandom_range(0, 1) == 1) new_req(p);
      end
      if (!t_req[0] && !t_req[1]) new_req(int'($urandom_range(0, 1)));
      slot(e);
    end
    while (t_req[0] || t_req[1]) slot(e);

    // Final memory image.
    for (int i = 0; i < 256; i++) chk($sformatf("mem_%0d", i), {24'd0, mem[i]}, {24'd0, ref_mem[i]});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 32, address width of both requesters and the memory port.
REQ-002 Parameter: DW, 32, data width; fixed at 32 because the memory is byte-addressed with big-endian 4-byte words.
REQ-003 Port: clk  input  1  single clock; all state changes on posedge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Ports: req0, req1  input  1 each  request from port 0 and port 1; held high until the matching ack.
REQ-006 Ports: we0, we1  input  1 each  1 = write, 0 = read; held stable while req is high.
REQ-007 Ports: addr0, addr1  input  AW each  byte address; held stable while req is high.
REQ-008 Ports: wd0, wd1  input  DW each  write data; held stable while req is high.
REQ-009 Ports: ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-010 Ports: rd0, rd1  output  DW each  registered read data; valid with ack; held until the next read ack on that port.
REQ-011 Ports: err0, err1  output  1 each  misalignment error, valid with ack.
REQ-012 Port: busy  output  1  high in any state other than IDLE.
REQ-013 Port: mem_address  output  AW  byte address to the data memory.
REQ-014 Port: mem_wd  output  DW  write word to the data memory.
REQ-015 Port: mem_we  output  1  write enable to the data memory; the memory writes on the posedge.
REQ-016 Port: mem_rd  input  DW  combinational read word from the data memory.

Function
REQ-017 FSM states are IDLE, ACCESS and DONE, with transitions IDLE->ACCESS when any req is high, ACCESS->DONE unconditionally, and DONE->IDLE unconditionally.
REQ-018 In IDLE the FSM SHALL latch winner, we, addr and wd into owner/we_q/addr_q/wd_q; later requester changes SHALL not affect the transaction in flight.
REQ-019 Arbitration is round-robin:
  - a single requester wins;
  - if both requesters are high, the port not in last_served wins;
  - last_served updates in DONE.
REQ-020 In ACCESS:
  - mem_address = addr_q and mem_wd = wd_q;
  - mem_we = we_q & ~rst;
  - on a read, mem_rd SHALL be captured into rd<owner> at the end of ACCESS.
REQ-021 In DONE, ack<owner> = 1 for exactly one cycle and ack of the other port = 0.
REQ-022 Latency is fixed: req sampled in IDLE at cycle N, memory access in cycle N+1, ack in cycle N+2; a new transaction can start at most every 3 cycles.
REQ-023 A req still high in IDLE after its ack is treated as a new request; requesters drop req on the edge after ack.
REQ-024 Outside ACCESS, mem_we = 0, and mem_address and mem_wd hold their last values.
REQ-025 A write leaves rd<owner> unchanged.
REQ-026 A request on the other port during ACCESS or DONE waits; it is not lost and is served next in round-robin order.
REQ-027 Arithmetic on addresses is not performed; the address is passed through unchanged, and memory wrap-around behaviour belongs to the memory.

Reset
REQ-028 When rst is high at a posedge:
  - state = IDLE, last_served = 1, so port 0 wins the first tie;
  - ack0/1 = 0, err0/1 = 0, rd0/1 = 0;
  - addr_q, wd_q and we_q = 0, owner = 0.
REQ-029 If rst is high during ACCESS, mem_we SHALL be 0 that cycle, so no memory write occurs.
REQ-029a No ack is produced for a transaction aborted by reset.
REQ-030 After rst is released, arbitration resumes in IDLE on the next cycle.

Configuration
REQ-031 Macro MEM_ARB_ALIGN_CHECK_EN controls alignment checking.
REQ-032 When MEM_ARB_ALIGN_CHECK_EN is defined, a request with addr_q[1:0] != 0:
  - SHALL keep mem_we = 0 in ACCESS;
  - SHALL leave rd<owner> unchanged;
  - SHALL complete with ack<owner> = 1 and err<owner> = 1 in DONE.
REQ-032a When MEM_ARB_ALIGN_CHECK_EN is defined, aligned requests complete with err = 0.
REQ-033 When MEM_ARB_ALIGN_CHECK_EN is undefined, err0/err1 are tied to 0 and every address is forwarded unchanged.

Verification
REQ-034 Port 0 write: addr0 = 0x10, wd0 = 0xDEADBEEF -> mem_we = 1 for exactly one cycle (N+1), ack0 at N+2, and a memory readback gives bytes DE AD BE EF at 0x10..0x13.
REQ-035 Port 1 read of 0x10 after REQ-034 -> ack1 at N+2, rd1 = 0xDEADBEEF, rd0 unchanged.
REQ-036 req0 and req1 both held high from reset release -> order of acks is 0,1,0,1, one ack per 3 cycles, and no ack is dropped.
REQ-037 Write 0x12345678 by port 1 to 0x20 with rst pulsed in its ACCESS cycle -> no ack, memory at 0x20 stays 0, busy = 0 next cycle.
REQ-038 With MEM_ARB_ALIGN_CHECK_EN: write to 0x22 -> ack0 = 1, err0 = 1, mem_we never asserted.
REQ-038a Without MEM_ARB_ALIGN_CHECK_EN: write to 0x22 -> the write occurs and err0 = 0.
